switch_box_config_loader: RTL and testbench



---
 rtl/switch_box_config_loader_if.sv | 22 ++
 rtl/switch_box_config_loader.sv | 138 +++++++++++++
 tb/tb_switch_box_config_loader.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/switch_box_config_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : switch_box_config_loader_if
// Purpose  : Bit-serial configuration stream carried into
//            switch_box_config_loader over a valid/ready handshake.
// Signals  : cfg_valid - cfg_data/cfg_last are valid this cycle
//            cfg_ready - the loader can accept a bit this cycle
//            cfg_data  - serial configuration bit
//            cfg_last  - marks the final bit of a frame
// Modports : master (stream source), slave (loader)
// Revision : 1.0 - initial release
// ============================================================================
interface switch_box_config_loader_if;
  logic cfg_valid;
  logic cfg_ready;
  logic cfg_data;
  logic cfg_last;

  modport master (output cfg_valid, output cfg_data, output cfg_last, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_data, input cfg_last, output cfg_ready);
endinterface
`default_nettype wire

// File: rtl/switch_box_config_loader.sv
`default_nettype none
// ============================================================================
// Module   : switch_box_config_loader
// Purpose  : Assembles a bit-serial configuration stream into a shadow
//            register. A complete frame is committed atomically to the
//            switch-box control bus, so the switches never see a partial
//            frame. Shifted-out shadow bits leave on scan_out_o so that
//            loaders can be daisy-chained.
// Ports    : clk         - clock; all state changes on the rising edge
//            rst_n       - asynchronous, active-low reset
//            cfg         - serial stream (slave side of the interface)
//            scan_out_o  - bit shifted out of shadow[0]
//            c_o         - committed switch controls, 6 bits per track:
//                          N-E, E-S, S-W, W-N, N-S, E-W
//            cfg_done_o  - 1-cycle pulse: frame committed to c_o
//            cfg_error_o - 1-cycle pulse: frame length error, frame dropped
// Revision : 1.0 - initial release
// ============================================================================
module switch_box_config_loader #(
  parameter int W = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  switch_box_config_loader_if.slave   cfg,
  output logic                        scan_out_o,
  output logic [6*W-1:0]              c_o,
  output logic                        cfg_done_o,
  output logic                        cfg_error_o
);

  localparam int CFG_BITS = 6 * W;
  localparam int CNT_W    = $clog2(CFG_BITS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [CFG_BITS-1:0]  shadow_q;
  logic [CFG_BITS-1:0]  shadow_d;
  logic [CFG_BITS-1:0]  c_q;
  logic                 scan_q;
  logic                 ready_q;
  logic                 done_q;
  logic                 err_q;
  logic                 accept;
  logic                 last_slot;

  // ready_q is registered and tracks the state, so the handshake never
  // depends combinationally on cfg_valid.
  assign accept    = cfg.cfg_valid && ready_q;
  // cnt_q counts bits already accepted; the frame's final bit arrives
  // while cnt_q sits at CFG_BITS-1.
  assign last_slot = (cnt_q == CNT_W'(CFG_BITS - 1));
  // New bits enter at the MSB so the first bit ends up in bit 0.
  assign shadow_d  = {cfg.cfg_data, shadow_q[CFG_BITS-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      c_q      <= '0;
      scan_q   <= 1'b0;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;

      // The shift path is independent of framing: an offending bit is still
      // shifted in, and a later full frame overwrites the stale content.
      if (accept) begin
        shadow_q <= shadow_d;
        scan_q   <= shadow_q[0];
      end

      case (state_q)
        S_IDLE: begin
          ready_q <= 1'b1;
          if (accept) begin
            if (cfg.cfg_last) begin
              err_q <= 1'b1;
              cnt_q <= '0;
            end else begin
              state_q <= S_LOAD;
              cnt_q   <= CNT_W'(1);
            end
          end
        end

        S_LOAD: begin
          ready_q <= 1'b1;
          if (accept) begin
            if (cfg.cfg_last && last_slot) begin
              state_q <= S_COMMIT;
              ready_q <= 1'b0;
              cnt_q   <= '0;
            end else if (cfg.cfg_last || last_slot) begin
              // Short frame (early last) or long frame (missing last).
              err_q   <= 1'b1;
              state_q <= S_IDLE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end

        S_COMMIT: begin
          c_q     <= shadow_q;
          done_q  <= 1'b1;
          cnt_q   <= '0;
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end

        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign cfg.cfg_ready = ready_q;
  assign scan_out_o    = scan_q;
  assign c_o           = c_q;
  assign cfg_done_o    = done_q;
  assign cfg_error_o   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_switch_box_config_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_switch_box_config_loader
// Purpose  : Self-checking bench for switch_box_config_loader (W=8, 48-bit
//            frames). A frame-level reference model predicts commit/error
//            outcomes, the committed value and the scan_out stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_switch_box_config_loader;

  localparam int W  = 8;
  localparam int NB = 6 * W;

  logic          clk;
  logic          rst_n;
  logic          scan_out;
  logic [NB-1:0] c;
  logic          done;
  logic          err;

  switch_box_config_loader_if cfg_if ();

  switch_box_config_loader #(.W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg         (cfg_if.slave),
    .scan_out_o  (scan_out),
    .c_o         (c),
    .cfg_done_o  (done),
    .cfg_error_o (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int both_cnt = 0;

  // Reference state: last committed frame, and every bit accepted since reset.
  logic [NB-1:0] model_c;
  bit            hist[$];

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (done === 1'b1) done_cnt++;
      if (err === 1'b1) err_cnt++;
      if (done === 1'b1 && err === 1'b1) both_cnt++;
    end
  end

  // Outcome of a frame by its length rules: 0 = still partial, 1 = commit, 2 = error.
  function automatic int frame_outcome(input int nbits, input int lastpos);
    if (lastpos == NB - 1 && nbits == NB) return 1;
    if (lastpos >= 0 && lastpos < NB - 1 && nbits == lastpos + 1) return 2;
    if (lastpos < 0 && nbits == NB) return 2;
    return 0;
  endfunction

  // Called at a falling edge; returns at the falling edge after the bit is accepted.
  task automatic send_bit(input logic d, input logic l, input bit gaps, output int waited);
    bit   ok;
    int   guard;
    logic exp_scan;
    waited = 0;
    guard  = 0;
    ok     = 1'b0;
    while (!ok) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_data  = 1'($urandom);
        cfg_if.cfg_last  = 1'($urandom);
        @(negedge clk);
        waited++;
      end else begin
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_data  = d;
        cfg_if.cfg_last  = l;
        ok = (cfg_if.cfg_ready === 1'b1);
        @(negedge clk);
        if (!ok) waited++;
      end
      guard++;
      if (!ok && guard > 200) begin
        checks++;
        failures++;
        $display("FAIL handshake_timeout: cfg_ready=%b, required 1 within 200 cycles", cfg_if.cfg_ready);
        ok = 1'b1;
      end
    end
    cfg_if.cfg_valid = 1'b0;
    exp_scan = (hist.size() >= NB) ? hist[hist.size() - NB] : 1'b0;
    hist.push_back(d);
    checks++;
    if (scan_out !== exp_scan) begin
      failures++;
      $display("FAIL scan_out: got %b, expected %b (accept #%0d)", scan_out, exp_scan, hist.size());
    end
  endtask

  task automatic send_frame(input logic [NB-1:0] val, input int nbits, input int lastpos,
                            input bit gaps, output int first_wait);
    int w;
    int d0;
    int e0;
    int outcome;
    d0 = done_cnt;
    e0 = err_cnt;
    first_wait = 0;
    outcome = frame_outcome(nbits, lastpos);
    for (int i = 0; i < nbits; i++) begin
      send_bit(val[i], (i == lastpos), gaps, w);
      if (i == 0) first_wait = w;
      if (i < nbits - 1) begin
        checks++;
        if (c !== model_c) begin
          failures++;
          $display("FAIL c_stable: got %h, expected %h (bit %0d)", c, model_c, i);
        end
      end
    end
    if (outcome == 1) begin
      checks++;
      if ({cfg_if.cfg_ready, done, c} !== {1'b0, 1'b0, model_c}) begin
        failures++;
        $display("FAIL commit_cycle: ready=%b done=%b c=%h, expected ready=0 done=0 c=%h",
                 cfg_if.cfg_ready, done, c, model_c);
      end
      @(negedge clk);
      model_c = val;
      checks++;
      if ({cfg_if.cfg_ready, done, err, c} !== {1'b1, 1'b1, 1'b0, model_c}) begin
        failures++;
        $display("FAIL commit_result: ready=%b done=%b err=%b c=%h, expected 1 1 0 %h",
                 cfg_if.cfg_ready, done, err, c, model_c);
      end
    end else if (outcome == 2) begin
      checks++;
      if ({cfg_if.cfg_ready, done, err, c} !== {1'b1, 1'b0, 1'b1, model_c}) begin
        failures++;
        $display("FAIL error_result: ready=%b done=%b err=%b c=%h, expected 1 0 1 %h",
                 cfg_if.cfg_ready, done, err, c, model_c);
      end
    end
    #1;
    checks++;
    if ((done_cnt - d0) != ((outcome == 1) ? 1 : 0) || (err_cnt - e0) != ((outcome == 2) ? 1 : 0)) begin
      failures++;
      $display("FAIL pulse_count: done=%0d err=%0d, expected done=%0d err=%0d",
               done_cnt - d0, err_cnt - e0, (outcome == 1) ? 1 : 0, (outcome == 2) ? 1 : 0);
    end
  endtask

  task automatic apply_reset(input int cycles);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < cycles; i++) begin
      cfg_if.cfg_valid = 1'($urandom);
      cfg_if.cfg_data  = 1'($urandom);
      cfg_if.cfg_last  = 1'($urandom);
      @(negedge clk);
      checks++;
      if ({c, cfg_if.cfg_ready, done, err, scan_out} !== '0) begin
        failures++;
        $display("FAIL reset_state: c=%h ready=%b done=%b err=%b scan=%b, expected all 0",
                 c, cfg_if.cfg_ready, done, err, scan_out);
      end
    end
    cfg_if.cfg_valid = 1'b0;
    rst_n   = 1'b1;
    model_c = '0;
    hist.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    apply_reset(8);
  endtask

  task automatic test_full_frame();
    int fw;
    send_frame(48'hA5A5_0F0F_1234, NB, NB - 1, 1'b0, fw);
  endtask

  task automatic test_gapped_frame();
    int fw;
    apply_reset(2);
    send_frame(48'hA5A5_0F0F_1234, NB, NB - 1, 1'b1, fw);
  endtask

  task automatic test_short_frame();
    int fw;
    send_frame(48'hFFFF_FFFF_FFFF, NB, NB - 1, 1'b0, fw);
    send_frame({$urandom, $urandom}, 21, 20, 1'b1, fw);
    send_frame(48'h0, NB, NB - 1, 1'b1, fw);
  endtask

  task automatic test_long_frame();
    int fw;
    send_frame({$urandom, $urandom}, NB, -1, 1'b1, fw);
  endtask

  task automatic test_reset_mid_frame();
    int fw;
    send_frame(48'hDEAD_BEEF_CAFE, NB, NB - 1, 1'b0, fw);
    send_frame({$urandom, $urandom}, 30, -1, 1'b1, fw);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({c, cfg_if.cfg_ready} !== '0) begin
      failures++;
      $display("FAIL async_reset: c=%h ready=%b, expected 0 0", c, cfg_if.cfg_ready);
    end
    @(negedge clk);
    apply_reset(3);
    send_frame(48'h1, NB, NB - 1, 1'b1, fw);
  endtask

  task automatic test_back_to_back();
    int fw;
    send_frame({$urandom, $urandom}, NB, NB - 1, 1'b0, fw);
    send_frame({$urandom, $urandom}, NB, NB - 1, 1'b0, fw);
    checks++;
    if (fw != 0) begin
      failures++;
      $display("FAIL back_to_back: first bit waited %0d cycles, expected 0", fw);
    end
  endtask

  task automatic test_daisy_chain();
    int fw;
    apply_reset(2);
    send_frame({$urandom, $urandom}, NB, NB - 1, 1'b1, fw);
    send_frame({$urandom, $urandom}, NB, NB - 1, 1'b1, fw);
  endtask

  task automatic test_random_frames();
    int fw;
    int kind;
    for (int n = 0; n < 8; n++) begin
      kind = $urandom_range(0, 2);
      if (kind == 0) send_frame({$urandom, $urandom}, NB, NB - 1, 1'($urandom), fw);
      else if (kind == 1) begin
        int lp;
        lp = $urandom_range(0, NB - 2);
        send_frame({$urandom, $urandom}, lp + 1, lp, 1'($urandom), fw);
      end else send_frame({$urandom, $urandom}, NB, -1, 1'($urandom), fw);
    end
  endtask

  initial begin
    rst_n            = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_data  = 1'b0;
    cfg_if.cfg_last  = 1'b0;
    model_c          = '0;
    test_reset();
    test_full_frame();
    test_gapped_frame();
    test_short_frame();
    test_long_frame();
    test_reset_mid_frame();
    test_back_to_back();
    test_daisy_chain();
    test_random_frames();
    checks++;
    if (both_cnt != 0) begin
      failures++;
      $display("FAIL done_and_error: overlapping pulses=%0d, expected 0", both_cnt);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
